traffic_phase_timer: RTL and testbench

Multi-phase, programmable-duration timer for the traffic controller. It sequences NUM_PHASES light phases, each with its own run-time-configurable duration, and pulses on every phase boundary and at the end of a full cycle. It also supports pause, single-shot or auto-repeat operation, and an emergency override. The controller FSM consumes `phase`, `phase_done` and `cycle_done` to drive the lamp outputs.

---
 rtl/traffic_phase_timer.sv | 174 +++++++++++++++++
 tb/tb_traffic_phase_timer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer
// Sequences NUM_PHASES light phases, each with its own programmable duration.
// It pulses phase_done on the last cycle of every phase and cycle_done on the
// last cycle of the last phase. It also supports pause, single-shot or
// auto-repeat operation, and an emergency override that parks the sequence at
// phase 0 until the override is released.
module traffic_phase_timer #(
    parameter int NUM_PHASES  = 4,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DUR = 30
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          repeat_en,
    input  logic                          pause,
    input  logic                          emergency,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_PHASES)-1:0] cfg_phase,
    input  logic [CNT_W-1:0]              cfg_dur,
    output logic [$clog2(NUM_PHASES)-1:0] phase,
    output logic [CNT_W-1:0]              remaining,
    output logic                          phase_done,
    output logic                          cycle_done,
    output logic                          busy,
    output logic                          emg_active
);

    localparam int PH_W     = $clog2(NUM_PHASES);
    // The duration table is padded to a power of two so that any phase index
    // selects a defined entry; the padding slots are never reached in operation.
    localparam int PH_SLOTS = 1 << PH_W;

    localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(NUM_PHASES - 1);
    localparam logic [CNT_W-1:0] DUR_RST    = CNT_W'(DEFAULT_DUR);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_EMERG = 2'd3
    } state_t;

    state_t             state_reg,   state_next;
    logic [PH_W-1:0]    phase_reg,   phase_next;
    logic [CNT_W-1:0]   cnt_reg,     cnt_next;
    logic [CNT_W-1:0]   cur_dur_reg, cur_dur_next;
    logic               start_q_reg;

    // Effective durations: a stored 0 behaves as a 1-cycle phase.
    logic [CNT_W-1:0]   dur_eff [PH_SLOTS];

    logic               start_pulse;
    logic               terminal;
    logic               last_phase;
    logic [PH_W-1:0]    succ_phase;

    // One duration register per phase. An index that matches no phase is
    // simply not decoded, so out-of-range writes have no effect.
    generate
        for (genvar gi = 0; gi < PH_SLOTS; gi++) begin : g_dur
            if (gi < NUM_PHASES) begin : g_reg
                logic [CNT_W-1:0] dur_reg;

                // Duration register write; reset restores the default.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        dur_reg <= DUR_RST;
                    end else if (cfg_we && (cfg_phase == PH_W'(gi))) begin
                        dur_reg <= cfg_dur;
                    end
                end

                assign dur_eff[gi] = (dur_reg == '0) ? ONE : dur_reg;
            end else begin : g_pad
                assign dur_eff[gi] = ONE;
            end
        end
    endgenerate

    assign start_pulse = start & ~start_q_reg;
    assign terminal    = (cnt_reg == (cur_dur_reg - ONE));
    assign last_phase  = (phase_reg == LAST_PHASE);
    assign succ_phase  = last_phase ? '0 : (phase_reg + PH_W'(1));

    // State, phase, counter and latched duration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            phase_reg   <= '0;
            cnt_reg     <= '0;
            cur_dur_reg <= '0;
            start_q_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            cnt_reg     <= cnt_next;
            cur_dur_reg <= cur_dur_next;
            start_q_reg <= start;
        end
    end

    // Next-state logic. Emergency overrides everything. In RUN the counter
    // always advances, and pause only chooses whether PAUSE follows. This way
    // the terminal count wins over pause and each PAUSE cycle adds exactly one
    // cycle to the phase. Loads read the registered table, so a write to the
    // same phase in the same cycle is seen only on the following entry.
    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        cnt_next     = cnt_reg;
        cur_dur_next = cur_dur_reg;

        if (emergency) begin
            state_next = ST_EMERG;
            phase_next = '0;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_pulse) begin
                        state_next   = ST_RUN;
                        phase_next   = '0;
                        cnt_next     = '0;
                        cur_dur_next = dur_eff[0];
                    end
                end
                ST_RUN: begin
                    if (terminal) begin
                        phase_next   = succ_phase;
                        cnt_next     = '0;
                        cur_dur_next = dur_eff[succ_phase];
                        if (last_phase && !repeat_en) begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        cnt_next = cnt_reg + ONE;
                        if (pause) begin
                            state_next = ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        state_next = ST_RUN;
                    end
                end
                ST_EMERG: begin
                    state_next   = ST_RUN;
                    phase_next   = '0;
                    cnt_next     = '0;
                    cur_dur_next = dur_eff[0];
                end
                default: begin
                    state_next = ST_IDLE;
                    phase_next = '0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches them directly.
    always_comb begin
        busy       = (state_reg == ST_RUN) || (state_reg == ST_PAUSE);
        emg_active = (state_reg == ST_EMERG);
        phase      = phase_reg;
        remaining  = busy ? (cur_dur_reg - cnt_reg) : '0;
        phase_done = (state_reg == ST_RUN) && terminal;
        cycle_done = (state_reg == ST_RUN) && terminal && last_phase;
    end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Testbench for traffic_phase_timer.
// The reference model tracks mode, phase and a countdown of cycles left, and
// it is compared against the DUT after every clock edge. Directed scenarios add
// literal expectations for pulse positions.
// A second instance with three phases covers the case of an unused phase index.
module tb_traffic_phase_timer;

    localparam int N   = 4;
    localparam int DEF = 30;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EMG   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       repeat_en = 1'b0;
    logic       pause = 1'b0;
    logic       emergency = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_phase = 2'd0;
    logic [7:0] cfg_dur = 8'd0;

    logic [1:0] phase;
    logic [7:0] remaining;
    logic       phase_done, cycle_done, busy, emg_active;

    logic       s3_start = 1'b0;
    logic       s3_cfg_we = 1'b0;
    logic [1:0] s3_cfg_phase = 2'd0;
    logic [7:0] s3_cfg_dur = 8'd0;
    logic [1:0] s3_phase;
    logic [7:0] s3_remaining;
    logic       s3_phase_done, s3_cycle_done, s3_busy, s3_emg_active;

    always #5 clk = ~clk;

    traffic_phase_timer #(.NUM_PHASES(4), .CNT_W(8), .DEFAULT_DUR(30)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .repeat_en(repeat_en),
        .pause(pause), .emergency(emergency), .cfg_we(cfg_we),
        .cfg_phase(cfg_phase), .cfg_dur(cfg_dur), .phase(phase),
        .remaining(remaining), .phase_done(phase_done), .cycle_done(cycle_done),
        .busy(busy), .emg_active(emg_active)
    );

    traffic_phase_timer #(.NUM_PHASES(3), .CNT_W(8), .DEFAULT_DUR(30)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(s3_start), .repeat_en(1'b0),
        .pause(1'b0), .emergency(1'b0), .cfg_we(s3_cfg_we),
        .cfg_phase(s3_cfg_phase), .cfg_dur(s3_cfg_dur), .phase(s3_phase),
        .remaining(s3_remaining), .phase_done(s3_phase_done),
        .cycle_done(s3_cycle_done), .busy(s3_busy), .emg_active(s3_emg_active)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mode, m_phase, m_rem, m_startq;
    int m_dur [N];
    int e_busy, e_pd;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    initial begin
        m_mode = M_IDLE; m_phase = 0; m_rem = 0; m_startq = 0;
        for (int i = 0; i < N; i++) m_dur[i] = DEF;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_mode = M_IDLE; m_phase = 0; m_rem = 0; m_startq = 0;
                for (int i = 0; i < N; i++) m_dur[i] = DEF;
            end else begin
                if (emergency) begin
                    m_mode = M_EMG; m_phase = 0; m_rem = 0;
                end else begin
                    case (m_mode)
                        M_IDLE: if (start && m_startq == 0) begin
                            m_mode = M_RUN; m_phase = 0; m_rem = eff(m_dur[0]);
                        end
                        M_RUN: begin
                            if (m_rem == 1) begin
                                if (m_phase == N - 1) begin
                                    m_phase = 0;
                                    if (repeat_en) m_rem = eff(m_dur[0]);
                                    else begin m_mode = M_IDLE; m_rem = 0; end
                                end else begin
                                    m_phase = m_phase + 1;
                                    m_rem = eff(m_dur[m_phase]);
                                end
                            end else begin
                                m_rem = m_rem - 1;
                                if (pause) m_mode = M_PAUSE;
                            end
                        end
                        M_PAUSE: if (!pause) m_mode = M_RUN;
                        default: begin
                            m_mode = M_RUN; m_phase = 0; m_rem = eff(m_dur[0]);
                        end
                    endcase
                end
                if (cfg_we && int'(cfg_phase) < N) m_dur[cfg_phase] = int'(cfg_dur);
                m_startq = int'(start);
            end
            #1;
            if (chk_en) begin
                e_busy = (m_mode == M_RUN || m_mode == M_PAUSE) ? 1 : 0;
                e_pd   = (m_mode == M_RUN && m_rem == 1) ? 1 : 0;
                check("model_phase", 32'(phase), 32'(e_busy ? m_phase : 0));
                check("model_remaining", 32'(remaining), 32'(e_busy ? m_rem : 0));
                check("model_phase_done", 32'(phase_done), 32'(e_pd));
                check("model_cycle_done", 32'(cycle_done), 32'((e_pd && m_phase == N - 1) ? 1 : 0));
                check("model_busy", 32'(busy), 32'(e_busy));
                check("model_emg_active", 32'(emg_active), 32'((m_mode == M_EMG) ? 1 : 0));
            end
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic cfg_write(input int p, input int d);
        cfg_we = 1'b1; cfg_phase = 2'(p); cfg_dur = 8'(d);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic set_durs(input int d0, input int d1, input int d2, input int d3);
        cfg_write(0, d0); cfg_write(1, d1); cfg_write(2, d2); cfg_write(3, d3);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_phase"}, 32'(phase), 32'd0);
        check({tag, "_remaining"}, 32'(remaining), 32'd0);
        check({tag, "_phase_done"}, 32'(phase_done), 32'd0);
        check({tag, "_cycle_done"}, 32'(cycle_done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_emg_active"}, 32'(emg_active), 32'd0);
    endtask

    logic [31:0] pd_v, cd_v, bz_v, em_v;
    logic [15:0] ph_v;
    int          w_idx [4];
    int          w_dur [4];

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single shot, durations {3,2,4,1}
        set_durs(3, 2, 4, 1);
        repeat_en = 1'b0;
        pd_v = '0; cd_v = '0; bz_v = '0;
        start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            pd_v[k] = phase_done; cd_v[k] = cycle_done; bz_v[k] = busy;
            if (k == 1) begin
                start = 1'b0;
                check("t1_first_remaining", 32'(remaining), 32'd3);
            end
        end
        check("t1_phase_done_pos", pd_v, 32'h0000_0628);
        check("t1_cycle_done_pos", cd_v, 32'h0000_0400);
        check("t1_busy_span", bz_v, 32'h0000_07FE);
        $display("txn single_shot pd=0x%0h cd=0x%0h busy=0x%0h", pd_v, cd_v, bz_v);

        // Auto repeat, all durations 2
        set_durs(2, 2, 2, 2);
        repeat_en = 1'b1;
        ph_v = '0; cd_v = '0;
        start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k <= 8) ph_v[2*k-2 +: 2] = phase;
            cd_v[k] = cycle_done;
            if (k == 1) start = 1'b0;
            if (k == 16) repeat_en = 1'b0;
        end
        check("t2_phase_seq", 32'(ph_v), 32'h0000_FA50);
        check("t2_cycle_done_pos", cd_v, 32'h0001_0100);
        $display("txn repeat phases=0x%0h cd=0x%0h", ph_v, cd_v);
        wait_idle();

        // Pause for 5 sampled cycles inside phase 1 (D=4)
        set_durs(2, 4, 2, 2);
        pd_v = '0;
        start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            pd_v[k] = phase_done;
            if (k >= 5 && k <= 9) check("t3_remaining_frozen", 32'(remaining), 32'd2);
            if (k == 1) start = 1'b0;
            if (k == 4) pause = 1'b1;
            if (k == 9) pause = 1'b0;
        end
        check("t3_phase_done_pos", pd_v, 32'h0000_0804);
        $display("txn pause pd=0x%0h", pd_v);
        wait_idle();

        // Emergency for 3 cycles inside phase 2
        set_durs(2, 2, 4, 2);
        pd_v = '0; em_v = '0;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            pd_v[k] = phase_done; em_v[k] = emg_active;
            if (k == 1) start = 1'b0;
            if (k == 6) emergency = 1'b1;
            if (k == 9) emergency = 1'b0;
            if (k == 10) begin
                check("t4_restart_phase", 32'(phase), 32'd0);
                check("t4_restart_remaining", 32'(remaining), 32'd2);
            end
        end
        check("t4_phase_done_pos", pd_v, 32'h0000_0014);
        check("t4_emg_span", em_v, 32'h0000_0380);
        $display("txn emergency pd=0x%0h emg=0x%0h", pd_v, em_v);
        wait_idle();

        // Write dur[1]=7 while phase 1 (D=3) is running
        set_durs(2, 3, 2, 2);
        repeat_en = 1'b1;
        pd_v = '0;
        start = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            pd_v[k] = phase_done;
            if (k == 1) start = 1'b0;
            if (k == 3) begin cfg_we = 1'b1; cfg_phase = 2'd1; cfg_dur = 8'd7; end
            if (k == 4) cfg_we = 1'b0;
            if (k == 10) repeat_en = 1'b0;
        end
        check("t5_phase_done_pos", pd_v, 32'h0004_0AA4);
        $display("txn live_write pd=0x%0h", pd_v);
        wait_idle();

        // Zero duration behaves as one cycle
        set_durs(2, 2, 0, 2);
        pd_v = '0; bz_v = '0;
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            pd_v[k] = phase_done; bz_v[k] = busy;
            if (k == 1) start = 1'b0;
            if (k == 5) check("t6_zero_dur_remaining", 32'(remaining), 32'd1);
        end
        check("t6_phase_done_pos", pd_v, 32'h0000_00B4);
        check("t6_busy_span", bz_v, 32'h0000_00FE);
        $display("txn zero_dur pd=0x%0h busy=0x%0h", pd_v, bz_v);

        // Reset mid-run after programming dur[0]=5
        cfg_write(0, 5);
        start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        check("t7_busy_before_reset", 32'(busy), 32'd1);
        check("t7_remaining_before_reset", 32'(remaining), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("t7_reset");
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t7_default_remaining", 32'(remaining), 32'd30);
        check("t7_phase_after_start", 32'(phase), 32'd0);
        $display("txn reset_mid_run remaining=%0d", remaining);

        // Three-phase instance: index 3 is not a phase and must be ignored
        w_idx = '{0, 1, 2, 3};
        w_dur = '{1, 1, 2, 9};
        for (int i = 0; i < 4; i++) begin
            s3_cfg_we = 1'b1; s3_cfg_phase = 2'(w_idx[i]); s3_cfg_dur = 8'(w_dur[i]);
            @(negedge clk);
        end
        s3_cfg_we = 1'b0;
        cd_v = '0; bz_v = '0;
        s3_start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            cd_v[k] = s3_cycle_done; bz_v[k] = s3_busy;
            if (k == 1) s3_start = 1'b0;
            if (k == 3) check("t8_last_phase_index", 32'(s3_phase), 32'd2);
        end
        check("t8_cycle_done_pos", cd_v, 32'h0000_0010);
        check("t8_busy_span", bz_v, 32'h0000_001E);
        $display("txn three_phase cd=0x%0h busy=0x%0h", cd_v, bz_v);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
